link_tlk: RTL and testbench

//  Transmit half of the ECI link layer. Packs VC-tagged data words from the upper layer into

---
 rtl/link_tlk_pkg.sv | 59 +++++
 rtl/link_tlk_credit_ctr.sv | 48 ++++
 rtl/link_tlk.sv | 157 +++++++++++++++
 tb/tb_link_tlk.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/link_tlk_pkg.sv
// Shared types, sizes and block encoders for the ECI link-layer transmit path.
package link_tlk_pkg;

  localparam int NUM_VC      = 13;
  localparam int NUM_WORDS   = 7;
  localparam int WORD_WIDTH  = 64;
  localparam int BLOCK_WIDTH = 512;

  localparam logic [3:0] VC_EMPTY = 4'hF;

  typedef enum logic [3:0] {
    BLK_TYPE_IDLE   = 4'h1,
    BLK_TYPE_SYNC   = 4'h2,
    BLK_TYPE_DATA   = 4'h3,
    BLK_TYPE_CREDIT = 4'h4
  } blk_type_e;

  // Block layout: [447:0] data words (slot i at 64*i), [511:508] block type,
  // [507:480] slot VCs (data blocks), [507] bank select and [503:496] credit
  // bits (credit blocks), [471:448] CRC field left zero for the lower layer.
  function automatic logic [BLOCK_WIDTH-1:0] encode_data_blk(
    input logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] data,
    input logic [NUM_WORDS-1:0][3:0]            vcs
  );
    logic [BLOCK_WIDTH-1:0] b;
    b = '0;
    b[NUM_WORDS*WORD_WIDTH-1:0] = data;
    b[507:480]                  = vcs;
    b[511:508]                  = BLK_TYPE_DATA;
    return b;
  endfunction

  function automatic logic [BLOCK_WIDTH-1:0] encode_sync_blk();
    logic [BLOCK_WIDTH-1:0] b;
    b = '0;
    b[511:508] = BLK_TYPE_SYNC;
    return b;
  endfunction

  function automatic logic [BLOCK_WIDTH-1:0] encode_idle_blk();
    logic [BLOCK_WIDTH-1:0] b;
    b = '0;
    b[511:508] = BLK_TYPE_IDLE;
    return b;
  endfunction

  function automatic logic [BLOCK_WIDTH-1:0] encode_credit_blk(
    input logic       hi_bank,
    input logic [7:0] bits
  );
    logic [BLOCK_WIDTH-1:0] b;
    b = '0;
    b[511:508] = BLK_TYPE_CREDIT;
    b[507]     = hi_bank;
    b[503:496] = bits;
    return b;
  endfunction

endpackage

// File: rtl/link_tlk_credit_ctr.sv
// Bank of saturating per-VC counters: +1 per inc bit, -dec per cycle, net applied.
module link_tlk_credit_ctr #(
  parameter int N     = 13,
  parameter int W     = 8,
  parameter int DEC_W = 3,
  parameter int INIT  = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0]              inc,
  input  logic [N-1:0][DEC_W-1:0]   dec,
  output logic [N-1:0][W-1:0]       cnt
);

  localparam logic [W+1:0] MAX = {2'b00, {W{1'b1}}};
  localparam logic [W-1:0] RST = W'(INIT);

  logic [N-1:0][W-1:0] cnt_d, cnt_q;

  // Net add/subtract in a wider domain, then clamp to [0, 2**W-1].
  function automatic logic [W-1:0] net_upd(
    input logic [W-1:0]     c,
    input logic             i,
    input logic [DEC_W-1:0] d
  );
    logic [W+1:0] up, dn;
    up = {2'b00, c} + {{(W+1){1'b0}}, i};
    dn = (W+2)'(d);
    if (up < dn) return '0;
    if ((up - dn) > MAX) return {W{1'b1}};
    return W'(up - dn);
  endfunction

  // Next count for every VC.
  always_comb begin
    cnt_d = cnt_q;
    for (int v = 0; v < N; v++) cnt_d[v] = net_upd(cnt_q[v], inc[v], dec[v]);
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= {N{RST}};
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/link_tlk.sv
// ECI link-layer transmit: packs word groups into blocks, tracks transmit
// credits, returns receive credits and inserts sync/idle blocks.
module link_tlk
  import link_tlk_pkg::*;
#(
  parameter int CREDIT_W      = 8,
  parameter int INIT_CREDITS  = 16,
  parameter int SYNC_INTERVAL = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] mob_data,
  input  logic [NUM_WORDS-1:0][3:0]            mob_vc_no,
  input  logic                                 mob_valid,
  output logic                                 mob_ready,
  input  logic [7:0]                           credits,
  input  logic                                 hi_credits,
  input  logic                                 credits_valid,
  input  logic [NUM_VC-1:0]                    rtn_vc_mask,
  output logic [BLOCK_WIDTH-1:0]               blk_tx_data,
  output logic                                 blk_tx_valid,
  input  logic                                 blk_tx_ready,
  output logic [NUM_VC-1:0]                    tx_credit_avail
);

  localparam int SCNT_W = $clog2(SYNC_INTERVAL);

  logic [NUM_VC-1:0][CREDIT_W-1:0] txcred, pending;
  logic [NUM_VC-1:0][2:0]          grp_cnt, tx_dec;
  logic [NUM_VC-1:0][0:0]          pend_dec;
  logic [NUM_VC-1:0]               cred_ret, pend_nz;
  logic                            grp_empty, credit_ok, starve;
  logic                            pend_lo, pend_hi, use_hi, data_go;
  logic                            do_load, sync_due;
  logic [7:0]                      crd_bits;
  blk_type_e                       blk_sel;

  logic [BLOCK_WIDTH-1:0] blk_tx_data_d, blk_tx_data_q;
  logic                   blk_tx_valid_d, blk_tx_valid_q;
  logic [SCNT_W-1:0]      sync_cnt_d, sync_cnt_q;
  logic                   sync_first_d, sync_first_q;
  logic                   last_hi_d, last_hi_q;

  link_tlk_credit_ctr #(.N(NUM_VC), .W(CREDIT_W), .DEC_W(3), .INIT(INIT_CREDITS)) u_txcred (
    .clk(clk), .rst_n(rst_n), .inc(cred_ret), .dec(tx_dec), .cnt(txcred)
  );

  link_tlk_credit_ctr #(.N(NUM_VC), .W(CREDIT_W), .DEC_W(1), .INIT(0)) u_pending (
    .clk(clk), .rst_n(rst_n), .inc(rtn_vc_mask), .dec(pend_dec), .cnt(pending)
  );

  // Per-VC slot census of the offered group and the credit check against it.
  always_comb begin
    grp_cnt   = '0;
    grp_empty = 1'b1;
    credit_ok = 1'b1;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (mob_vc_no[i] != VC_EMPTY) grp_empty = 1'b0;
      for (int v = 0; v < NUM_VC; v++)
        if (mob_vc_no[i] == 4'(v)) grp_cnt[v] = grp_cnt[v] + 3'd1;
    end
    for (int v = 0; v < NUM_VC; v++)
      if (CREDIT_W'(grp_cnt[v]) > txcred[v]) credit_ok = 1'b0;
  end

  // Partner credit field to per-VC bits; pending-return summaries for CREDIT blocks.
  always_comb begin
    starve = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      cred_ret[v] = credits_valid & credits[v % 8] & (hi_credits == (v >= 8));
      pend_nz[v]  = |pending[v];
      if (pending[v][CREDIT_W-1]) starve = 1'b1;
    end
    pend_lo  = |pend_nz[7:0];
    pend_hi  = |pend_nz[12:8];
    use_hi   = pend_hi & (!pend_lo | !last_hi_q);
    crd_bits = use_hi ? {3'b000, pend_nz[12:8]} : pend_nz[7:0];
  end

  assign do_load  = !blk_tx_valid_q | blk_tx_ready;
  assign sync_due = sync_first_q | (sync_cnt_q == SCNT_W'(SYNC_INTERVAL - 1));
  // A starving return path pushes CREDIT ahead of DATA.
  assign data_go  = mob_valid & credit_ok & !starve;

  // Block selection; an all-empty group is consumed without producing DATA.
  always_comb begin
    blk_sel   = BLK_TYPE_IDLE;
    mob_ready = 1'b0;
    if (sync_due) begin
      blk_sel = BLK_TYPE_SYNC;
    end else begin
      mob_ready = do_load & data_go;
      if (data_go && !grp_empty)  blk_sel = BLK_TYPE_DATA;
      else if (pend_lo || pend_hi) blk_sel = BLK_TYPE_CREDIT;
    end
  end

  // Counter decrements caused by the block being loaded this cycle.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      pend_dec[v] = (do_load && blk_sel == BLK_TYPE_CREDIT && pend_nz[v] &&
                     ((v >= 8) == use_hi)) ? 1'b1 : 1'b0;
      tx_dec[v]   = (do_load && blk_sel == BLK_TYPE_DATA) ? grp_cnt[v] : 3'd0;
    end
  end

  // Output stage and sync scheduling next state.
  always_comb begin
    blk_tx_valid_d = blk_tx_valid_q;
    blk_tx_data_d  = blk_tx_data_q;
    sync_cnt_d     = sync_cnt_q;
    sync_first_d   = sync_first_q;
    last_hi_d      = last_hi_q;
    if (do_load) begin
      blk_tx_valid_d = 1'b1;
      sync_first_d   = 1'b0;
      sync_cnt_d     = sync_cnt_q + SCNT_W'(1);
      case (blk_sel)
        BLK_TYPE_SYNC: begin
          blk_tx_data_d = encode_sync_blk();
          sync_cnt_d    = '0;
        end
        BLK_TYPE_DATA:   blk_tx_data_d = encode_data_blk(mob_data, mob_vc_no);
        BLK_TYPE_CREDIT: begin
          blk_tx_data_d = encode_credit_blk(use_hi, crd_bits);
          last_hi_d     = use_hi;
        end
        default:         blk_tx_data_d = encode_idle_blk();
      endcase
    end
  end

  // Output register and scheduling state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_tx_valid_q <= 1'b0;
      blk_tx_data_q  <= '0;
      sync_cnt_q     <= '0;
      sync_first_q   <= 1'b1;
      last_hi_q      <= 1'b1;
    end else begin
      blk_tx_valid_q <= blk_tx_valid_d;
      blk_tx_data_q  <= blk_tx_data_d;
      sync_cnt_q     <= sync_cnt_d;
      sync_first_q   <= sync_first_d;
      last_hi_q      <= last_hi_d;
    end
  end

  assign blk_tx_data  = blk_tx_data_q;
  assign blk_tx_valid = blk_tx_valid_q;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) tx_credit_avail[v] = |txcred[v];
  end

endmodule

// File: tb/tb_link_tlk.sv
// Directed bench for link_tlk: sync cadence, data/credit flow, backpressure, saturation.
module tb_link_tlk;

  logic               clk, rst_n;
  logic [6:0][63:0]   mob_data;
  logic [6:0][3:0]    mob_vc_no;
  logic               mob_valid, mob_ready;
  logic [7:0]         credits;
  logic               hi_credits, credits_valid;
  logic [12:0]        rtn_vc_mask;
  logic [511:0]       blk_tx_data;
  logic               blk_tx_valid, blk_tx_ready;
  logic [12:0]        tx_credit_avail;

  int n_vec = 0;
  int n_err = 0;

  link_tlk dut (
    .clk(clk), .rst_n(rst_n), .mob_data(mob_data), .mob_vc_no(mob_vc_no),
    .mob_valid(mob_valid), .mob_ready(mob_ready), .credits(credits),
    .hi_credits(hi_credits), .credits_valid(credits_valid), .rtn_vc_mask(rtn_vc_mask),
    .blk_tx_data(blk_tx_data), .blk_tx_valid(blk_tx_valid), .blk_tx_ready(blk_tx_ready),
    .tx_credit_avail(tx_credit_avail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk_ctl(input logic [3:0] t);
    logic [511:0] b = '0;
    b[511:508] = t;
    return b;
  endfunction

  function automatic logic [511:0] mk_data(input logic [3:0] vc, input logic [63:0] base);
    logic [511:0] b = '0;
    b[511:508] = 4'h3;
    for (int i = 0; i < 7; i++) begin
      b[64*i +: 64]   = base + 64'(i);
      b[480+4*i +: 4] = vc;
    end
    return b;
  endfunction

  function automatic logic [511:0] mk_crd(input logic hi, input logic [7:0] bits);
    logic [511:0] b = '0;
    b[511:508] = 4'h4;
    b[507]     = hi;
    b[503:496] = bits;
    return b;
  endfunction

  task automatic set_group(input logic [3:0] vc, input logic [63:0] base);
    for (int i = 0; i < 7; i++) begin
      mob_data[i]  = base + 64'(i);
      mob_vc_no[i] = vc;
    end
    mob_valid = 1'b1;
  endtask

  // Wait (bounded) for acceptance, then step through the load edge.
  task automatic wait_load(input string tag);
    bit ok = 1'b0;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (mob_ready) begin ok = 1'b1; break; end
      step();
    end
    if (ok) step();
    chk({tag, "_acc"}, 512'(ok), 512'(1));
    mob_valid = 1'b0;
  endtask

  task automatic step_nosync();
    step();
    if (blk_tx_data[511:508] == 4'h2) step();
  endtask

  initial begin
    int idle_cnt;
    bit any_rdy;
    rst_n = 1'b0; blk_tx_ready = 1'b1; mob_valid = 1'b0; mob_data = '0;
    mob_vc_no = {7{4'hF}}; credits = '0; hi_credits = 1'b0; credits_valid = 1'b0;
    rtn_vc_mask = '0;
    repeat (3) step();

    // reset state
    chk("rst_valid", 512'(blk_tx_valid), 512'(0));
    chk("rst_data", blk_tx_data, 512'(0));
    chk("rst_ready", 512'(mob_ready), 512'(0));
    chk("rst_avail", 512'(tx_credit_avail), 512'(13'h1FFF));
    chk("rst_txcred0", 512'(dut.txcred[0]), 512'(16));

    // first block SYNC, then IDLE, next SYNC 64 blocks later
    rst_n = 1'b1;
    step();
    chk("first_sync", blk_tx_data, mk_ctl(4'h2));
    chk("first_valid", 512'(blk_tx_valid), 512'(1));
    step();
    chk("first_idle", blk_tx_data, mk_ctl(4'h1));
    idle_cnt = 1;
    for (int k = 2; k < 64; k++) begin
      step();
      if (blk_tx_data == mk_ctl(4'h1) && blk_tx_valid) idle_cnt++;
    end
    chk("idle_run", 512'(idle_cnt), 512'(63));
    step();
    chk("sync_64", blk_tx_data, mk_ctl(4'h2));

    // 7xVC2 groups: 16 -> 9 -> 2, third stalls
    set_group(4'd2, 64'hA100);
    wait_load("g1");
    chk("g1_blk", blk_tx_data, mk_data(4'd2, 64'hA100));
    chk("g1_txcred", 512'(dut.txcred[2]), 512'(9));
    set_group(4'd2, 64'hA200);
    wait_load("g2");
    chk("g2_blk", blk_tx_data, mk_data(4'd2, 64'hA200));
    chk("g2_txcred", 512'(dut.txcred[2]), 512'(2));
    set_group(4'd2, 64'hA300);
    #1;
    any_rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (mob_ready) any_rdy = 1'b1;
      step();
    end
    chk("g3_stall", 512'(any_rdy), 512'(0));

    // five single-credit returns on VC2 unblock the stalled group
    credits = 8'h04; hi_credits = 1'b0;
    for (int p = 0; p < 5; p++) begin
      credits_valid = 1'b1;
      step();
      credits_valid = 1'b0;
      if (p < 4) begin
        #1;
        if (mob_ready) any_rdy = 1'b1;
        step();
      end
    end
    chk("g3_early", 512'(any_rdy), 512'(0));
    chk("g3_txcred7", 512'(dut.txcred[2]), 512'(7));
    wait_load("g3");
    chk("g3_blk", blk_tx_data, mk_data(4'd2, 64'hA300));
    chk("g3_txcred0", 512'(dut.txcred[2]), 512'(0));
    chk("g3_avail", 512'(tx_credit_avail[2]), 512'(0));

    // backpressure while a DATA block is held
    set_group(4'd5, 64'hB100);
    wait_load("bp1");
    chk("bp1_blk", blk_tx_data, mk_data(4'd5, 64'hB100));
    blk_tx_ready = 1'b0;
    set_group(4'd6, 64'hB200);
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_hold", blk_tx_data, mk_data(4'd5, 64'hB100));
      chk("bp_ready", 512'(mob_ready), 512'(0));
      step();
    end
    chk("bp_valid", 512'(blk_tx_valid), 512'(1));
    blk_tx_ready = 1'b1;
    wait_load("bp2");
    chk("bp2_blk", blk_tx_data, mk_data(4'd6, 64'hB200));

    // credit return on VC3 and VC10: lo bank first, then hi
    rtn_vc_mask = 13'h0408;
    step();
    rtn_vc_mask = '0;
    step_nosync();
    chk("crd_lo", blk_tx_data, mk_crd(1'b0, 8'h08));
    step_nosync();
    chk("crd_hi", blk_tx_data, mk_crd(1'b1, 8'h04));
    chk("pend3", 512'(dut.pending[3]), 512'(0));
    chk("pend10", 512'(dut.pending[10]), 512'(0));
    step_nosync();
    chk("crd_idle", blk_tx_data, mk_ctl(4'h1));

    // VC0 credit saturation
    credits = 8'h01; hi_credits = 1'b0; credits_valid = 1'b1;
    repeat (100) step();
    chk("sat_mid", 512'(dut.txcred[0]), 512'(116));
    repeat (150) step();
    credits_valid = 1'b0;
    chk("sat_255", 512'(dut.txcred[0]), 512'(255));
    chk("sat_vc1", 512'(dut.txcred[1]), 512'(16));
    credits = 8'h01; hi_credits = 1'b1; credits_valid = 1'b1;
    step();
    credits_valid = 1'b0;
    chk("hi_vc8", 512'(dut.txcred[8]), 512'(17));
    chk("hi_vc0", 512'(dut.txcred[0]), 512'(255));

    // asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 512'(blk_tx_valid), 512'(0));
    chk("mrst_data", blk_tx_data, 512'(0));
    chk("mrst_vc8", 512'(dut.txcred[8]), 512'(16));
    chk("mrst_avail", 512'(tx_credit_avail), 512'(13'h1FFF));
    step();
    rst_n = 1'b1;
    step();
    chk("mrst_sync", blk_tx_data, mk_ctl(4'h2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
